// File: rtl/inference_scheduler_pkg.sv
// Shared safety parameters: scheduler FSM encodings, default engine timeout,
// safety state encodings and index-width helper.
package inference_scheduler_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam int unsigned DEF_TIMEOUT = 32'd255;

  typedef enum logic [1:0] {
    SAFE_RUN      = 2'd0,
    SAFE_DEGRADED = 2'd1,
    SAFE_STOP     = 2'd2
  } safety_state_e;

  // Index width that stays at least one bit for single-entry vectors.
  function automatic int unsigned idx_w(input int unsigned n);
    if (n > 32'd1) begin
      return $clog2(n);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/inference_scheduler_if.sv
// Sensor-channel handshake plus engine start/done bus between the scheduler
// (master) and the channels/engine environment (slave).
interface inference_scheduler_if
  import inference_scheduler_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 16
) ();

  localparam int unsigned CH_W = idx_w(NUM_CH);

  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_ready;
  logic                     eng_start;
  logic [DATA_W-1:0]        eng_data;
  logic [CH_W-1:0]          eng_ch;
  logic                     eng_done;
  logic                     eng_anomaly;

  modport master (
    input  ch_valid, ch_data, eng_done, eng_anomaly,
    output ch_ready, eng_start, eng_data, eng_ch
  );

  modport slave (
    output ch_valid, ch_data, eng_done, eng_anomaly,
    input  ch_ready, eng_start, eng_data, eng_ch
  );

endinterface

// File: rtl/inference_scheduler_rr_arbiter.sv
// Round-robin grant: one-hot to the first requester at or above ptr_i,
// wrapping around; zero when nobody requests.
module rr_arbiter
  import inference_scheduler_pkg::*;
#(
  parameter  int unsigned N = 4,
  localparam int unsigned W = idx_w(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] grant_o
);

  logic         found_s;
  logic [W-1:0] idx_s;

  // Priority search starting at the pointer.
  always_comb begin
    grant_o = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int i = 0; i < int'(N); i++) begin
      idx_s = W'((int'(ptr_i) + i) % int'(N));
      if (!found_s && req_i[idx_s]) begin
        grant_o[idx_s] = 1'b1;
        found_s        = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/inference_scheduler.sv
// Shares one inference engine among NUM_CH sensor channels round-robin,
// tracks per-channel anomaly verdicts and latches engine/scheduler faults.
module inference_scheduler
  import inference_scheduler_pkg::*;
#(
  parameter  int unsigned NUM_CH  = 4,
  parameter  int unsigned DATA_W  = 16,
  parameter  int unsigned TIMEOUT = DEF_TIMEOUT,
  localparam int unsigned CH_W    = idx_w(NUM_CH),
  localparam int unsigned CNT_W   = idx_w(TIMEOUT + 32'd1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  inference_scheduler_if.master      bus,
  output logic [NUM_CH-1:0]          anomaly_vec_o,
  output logic                       ml_anomaly_o,
  output logic                       sensor_fault_o,
  output logic [CH_W-1:0]            fault_ch_o
);

  logic [1:0]        state_q,        state_d;
  logic [CH_W-1:0]   rr_ptr_q,       rr_ptr_d;
  logic [CNT_W-1:0]  cnt_q,          cnt_d;
  logic              eng_start_q,    eng_start_d;
  logic [DATA_W-1:0] eng_data_q,     eng_data_d;
  logic [CH_W-1:0]   eng_ch_q,       eng_ch_d;
  logic [NUM_CH-1:0] anomaly_vec_q,  anomaly_vec_d;
  logic              ml_anomaly_q,   ml_anomaly_d;
  logic              sensor_fault_q, sensor_fault_d;
  logic [CH_W-1:0]   fault_ch_q,     fault_ch_d;

  logic [NUM_CH-1:0] grant_s;
  logic [CH_W-1:0]   grant_idx_s;
  logic [CNT_W-1:0]  cnt_inc_s;

  rr_arbiter #(.N(NUM_CH)) u_rr_arbiter (
    .req_i   (bus.ch_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant_s)
  );

  assign bus.ch_ready = (state_q == ST_IDLE) ? grant_s : '0;
  assign cnt_inc_s    = cnt_q + CNT_W'(1);

  // One-hot grant to binary channel index.
  always_comb begin
    grant_idx_s = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (grant_s[i]) begin
        grant_idx_s = CH_W'(i);
      end else begin
        grant_idx_s = grant_idx_s;
      end
    end
  end

  // Scheduler next-state and output-register update.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    cnt_d          = cnt_q;
    eng_start_d    = 1'b0;
    eng_data_d     = eng_data_q;
    eng_ch_d       = eng_ch_q;
    anomaly_vec_d  = anomaly_vec_q;
    ml_anomaly_d   = 1'b0;
    sensor_fault_d = sensor_fault_q;
    fault_ch_d     = fault_ch_q;
    case (state_q)
      ST_IDLE: begin
        // A spurious completion outranks a simultaneous transfer.
        if (bus.eng_done) begin
          state_d        = ST_FAULT;
          sensor_fault_d = 1'b1;
          fault_ch_d     = eng_ch_q;
        end else if (|grant_s) begin
          state_d     = ST_ISSUE;
          eng_start_d = 1'b1;
          eng_data_d  = bus.ch_data[int'(grant_idx_s)*int'(DATA_W) +: DATA_W];
          eng_ch_d    = grant_idx_s;
          rr_ptr_d    = (grant_idx_s == CH_W'(NUM_CH - 32'd1)) ? CH_W'(0)
                                                               : grant_idx_s + CH_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bus.eng_done) begin
          state_d        = ST_FAULT;
          sensor_fault_d = 1'b1;
          fault_ch_d     = eng_ch_q;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_inc_s;
        // Completion wins even on the cycle the count reaches TIMEOUT.
        if (bus.eng_done) begin
          state_d                 = ST_IDLE;
          anomaly_vec_d[eng_ch_q] = bus.eng_anomaly;
          ml_anomaly_d            = bus.eng_anomaly;
        end else if (cnt_inc_s == CNT_W'(TIMEOUT)) begin
          state_d        = ST_FAULT;
          sensor_fault_d = 1'b1;
          fault_ch_d     = eng_ch_q;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d        = ST_FAULT;
        sensor_fault_d = 1'b1;
        fault_ch_d     = eng_ch_q;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      rr_ptr_q       <= '0;
      cnt_q          <= '0;
      eng_start_q    <= 1'b0;
      eng_data_q     <= '0;
      eng_ch_q       <= '0;
      anomaly_vec_q  <= '0;
      ml_anomaly_q   <= 1'b0;
      sensor_fault_q <= 1'b0;
      fault_ch_q     <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      cnt_q          <= cnt_d;
      eng_start_q    <= eng_start_d;
      eng_data_q     <= eng_data_d;
      eng_ch_q       <= eng_ch_d;
      anomaly_vec_q  <= anomaly_vec_d;
      ml_anomaly_q   <= ml_anomaly_d;
      sensor_fault_q <= sensor_fault_d;
      fault_ch_q     <= fault_ch_d;
    end
  end

  assign bus.eng_start   = eng_start_q;
  assign bus.eng_data    = eng_data_q;
  assign bus.eng_ch      = eng_ch_q;
  assign anomaly_vec_o   = anomaly_vec_q;
  assign ml_anomaly_o    = ml_anomaly_q;
  assign sensor_fault_o  = sensor_fault_q;
  assign fault_ch_o      = fault_ch_q;

endmodule

// File: tb/tb_inference_scheduler.sv
// Directed bench for inference_scheduler: a transaction table for grant order,
// capture and anomaly tracking, plus sequences for timeout, spurious done and reset.
module tb_inference_scheduler;
  import inference_scheduler_pkg::*;

  localparam int NUM_CH  = 4;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] anomaly_vec;
  logic       ml_anomaly;
  logic       sensor_fault;
  logic [1:0] fault_ch;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inference_scheduler_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  inference_scheduler #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .anomaly_vec_o  (anomaly_vec),
    .ml_anomaly_o   (ml_anomaly),
    .sensor_fault_o (sensor_fault),
    .fault_ch_o     (fault_ch)
  );

  typedef struct {
    bit         rst;
    logic [3:0] valid;
    logic [15:0] base;
    logic [3:0] exp_ready;
    logic [1:0] exp_ch;
    logic [15:0] exp_data;
    logic       anom;
    logic [3:0] exp_vec;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_lanes(input logic [15:0] base);
    for (int c = 0; c < NUM_CH; c++) begin
      bus.ch_data[c*DATA_W +: DATA_W] = base + 16'(c);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_eng_start"}, 32'(bus.eng_start), 32'h0);
    chk({tag, "_eng_data"},  32'(bus.eng_data),  32'h0);
    chk({tag, "_eng_ch"},    32'(bus.eng_ch),    32'h0);
    chk({tag, "_vec"},       32'(anomaly_vec),   32'h0);
    chk({tag, "_ml"},        32'(ml_anomaly),    32'h0);
    chk({tag, "_fault"},     32'(sensor_fault),  32'h0);
    chk({tag, "_fault_ch"},  32'(fault_ch),      32'h0);
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    bus.ch_valid    = '0;
    bus.ch_data     = '0;
    bus.eng_done    = 1'b0;
    bus.eng_anomaly = 1'b0;
    #1;
    chk_reset_vals("rst");
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic start_txn(input logic [3:0] v, input logic [15:0] base);
    fill_lanes(base);
    bus.ch_valid = v;
    tick();
    bus.ch_valid = '0;
  endtask

  task automatic full_txn(input logic [3:0] v, input logic [15:0] base, input logic anom);
    start_txn(v, base);
    tick();
    tick();
    bus.eng_done    = 1'b1;
    bus.eng_anomaly = anom;
    tick();
    bus.eng_done    = 1'b0;
    bus.eng_anomaly = 1'b0;
  endtask

  initial begin
    bus.ch_valid    = '0;
    bus.ch_data     = '0;
    bus.eng_done    = 1'b0;
    bus.eng_anomaly = 1'b0;

    //             rst   valid    base      ready    ch    data      anom  vec
    vecs[0] = '{1'b1, 4'b0100, 16'h1232, 4'b0100, 2'd2, 16'h1234, 1'b0, 4'b0000};
    vecs[1] = '{1'b1, 4'b1111, 16'hA000, 4'b0001, 2'd0, 16'hA000, 1'b0, 4'b0000};
    vecs[2] = '{1'b0, 4'b1111, 16'hA010, 4'b0010, 2'd1, 16'hA011, 1'b1, 4'b0010};
    vecs[3] = '{1'b0, 4'b1111, 16'hA020, 4'b0100, 2'd2, 16'hA022, 1'b0, 4'b0010};
    vecs[4] = '{1'b0, 4'b1111, 16'hA030, 4'b1000, 2'd3, 16'hA033, 1'b1, 4'b1010};
    vecs[5] = '{1'b0, 4'b1111, 16'hA040, 4'b0001, 2'd0, 16'hA040, 1'b0, 4'b1010};
    vecs[6] = '{1'b0, 4'b0100, 16'hB000, 4'b0100, 2'd2, 16'hB002, 1'b0, 4'b1010};
    vecs[7] = '{1'b0, 4'b0011, 16'hB010, 4'b0001, 2'd0, 16'hB010, 1'b0, 4'b1010};
    vecs[8] = '{1'b0, 4'b0010, 16'hB020, 4'b0010, 2'd1, 16'hB021, 1'b0, 4'b1000};
    vecs[9] = '{1'b0, 4'b1001, 16'hB030, 4'b1000, 2'd3, 16'hB033, 1'b0, 4'b0000};

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].rst) do_reset();
      chk($sformatf("v%0d_ready_idle", i), 32'(bus.ch_ready), 32'h0);
      fill_lanes(vecs[i].base);
      bus.ch_valid = vecs[i].valid;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(bus.ch_ready), 32'(vecs[i].exp_ready));
      tick();
      bus.ch_valid = '0;
      chk($sformatf("v%0d_start", i), 32'(bus.eng_start), 32'h1);
      chk($sformatf("v%0d_data", i), 32'(bus.eng_data), 32'(vecs[i].exp_data));
      chk($sformatf("v%0d_ch", i), 32'(bus.eng_ch), 32'(vecs[i].exp_ch));
      tick();
      chk($sformatf("v%0d_start_off", i), 32'(bus.eng_start), 32'h0);
      tick();
      bus.eng_done    = 1'b1;
      bus.eng_anomaly = vecs[i].anom;
      tick();
      bus.eng_done    = 1'b0;
      bus.eng_anomaly = 1'b0;
      chk($sformatf("v%0d_ml", i), 32'(ml_anomaly), 32'(vecs[i].anom));
      chk($sformatf("v%0d_vec", i), 32'(anomaly_vec), 32'(vecs[i].exp_vec));
      chk($sformatf("v%0d_fault", i), 32'(sensor_fault), 32'h0);
      tick();
      chk($sformatf("v%0d_ml_off", i), 32'(ml_anomaly), 32'h0);
    end

    // eng_done on the last allowed cycle: no fault, back to IDLE.
    do_reset();
    start_txn(4'b0100, 16'h5550);
    repeat (TIMEOUT) tick();
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    chk("edge_no_fault", 32'(sensor_fault), 32'h0);
    bus.ch_valid = 4'b0001;
    #1;
    chk("edge_idle_ready", 32'(bus.ch_ready), 32'h1);
    bus.ch_valid = '0;
    tick();

    // Timeout on channel 3.
    do_reset();
    start_txn(4'b1000, 16'hC000);
    chk("to_ch", 32'(bus.eng_ch), 32'h3);
    repeat (TIMEOUT) tick();
    chk("to_not_yet", 32'(sensor_fault), 32'h0);
    tick();
    chk("to_fault", 32'(sensor_fault), 32'h1);
    chk("to_fault_ch", 32'(fault_ch), 32'h3);
    bus.ch_valid = 4'b1111;
    #1;
    chk("to_ready_blocked", 32'(bus.ch_ready), 32'h0);
    bus.eng_done    = 1'b1;
    bus.eng_anomaly = 1'b1;
    repeat (5) tick();
    bus.eng_done    = 1'b0;
    bus.eng_anomaly = 1'b0;
    chk("to_fault_held", 32'(sensor_fault), 32'h1);
    chk("to_no_start", 32'(bus.eng_start), 32'h0);
    chk("to_no_ml", 32'(ml_anomaly), 32'h0);
    chk("to_ready_held", 32'(bus.ch_ready), 32'h0);

    // Spurious eng_done in IDLE after a normal channel-2 transaction.
    do_reset();
    full_txn(4'b0100, 16'h7770, 1'b0);
    chk("sp_clean", 32'(sensor_fault), 32'h0);
    tick();
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    chk("sp_fault", 32'(sensor_fault), 32'h1);
    chk("sp_fault_ch", 32'(fault_ch), 32'h2);
    chk("sp_no_ml", 32'(ml_anomaly), 32'h0);

    // Reset pulsed during WAIT, then channel 0 served normally.
    do_reset();
    full_txn(4'b0010, 16'h8880, 1'b1);
    chk("mr_vec_pre", 32'(anomaly_vec), 32'h2);
    tick();
    start_txn(4'b1000, 16'hD000);
    tick();
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mr");
    chk("mr_ready", 32'(bus.ch_ready), 32'h0);
    tick();
    rst_n = 1'b1;
    fill_lanes(16'hE000);
    bus.ch_valid = 4'b0001;
    #1;
    chk("mr_ready0", 32'(bus.ch_ready), 32'h1);
    tick();
    bus.ch_valid = '0;
    chk("mr_start", 32'(bus.eng_start), 32'h1);
    chk("mr_data", 32'(bus.eng_data), 32'hE000);
    chk("mr_ch", 32'(bus.eng_ch), 32'h0);
    tick();
    tick();
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    chk("mr_done_fault", 32'(sensor_fault), 32'h0);
    chk("mr_done_vec", 32'(anomaly_vec), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inference_scheduler.md
INFERENCE_SCHEDULER -- requirements
Module: inference_scheduler

Interface
REQ-001 Parameter NUM_CH, default 4, number of sensor channels sharing the one inference engine.
REQ-002 Parameter DATA_W, default 16, sample width in bits.
REQ-003 Parameter TIMEOUT, default 255, maximum cycles to wait for eng_done before declaring a fault.
REQ-004 Port clk  in  1  clock; all state changes on its rising edge.
REQ-005 Port rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port ch_valid  in  NUM_CH  per-channel sample-valid signal.
REQ-007 Port ch_data  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
REQ-008 Port ch_ready  out  NUM_CH  per-channel accept signal; a transfer occurs when ch_valid[i]&ch_ready[i].
REQ-009 Port eng_start  out  1  one-cycle engine start pulse.
REQ-010 Port eng_data  out  DATA_W  sample presented to the engine, held stable while busy.
REQ-011 Port eng_ch  out  clog2(NUM_CH)  channel index of the sample in flight.
REQ-012 Port eng_done  in  1  one-cycle engine completion pulse.
REQ-013 Port eng_anomaly  in  1  engine verdict, valid only when eng_done=1.
REQ-014 Port anomaly_vec  out  NUM_CH  sticky per-channel anomaly flags.
REQ-015 Port ml_anomaly  out  1  one-cycle pulse per anomalous result; feeds the safety state machine.
REQ-016 Port sensor_fault  out  1  latched scheduler/engine fault; feeds the safety state machine.
REQ-017 Port fault_ch  out  clog2(NUM_CH)  channel in flight when the fault latched.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, FAULT.
REQ-019 In IDLE, ch_ready is combinational: a one-hot grant to the first channel with ch_valid=1, searched from rr_ptr upward with wrap; all zero when no channel is valid.
REQ-020 On a transfer in IDLE: capture ch_data into eng_data, capture the index into eng_ch, set rr_ptr = (granted index + 1) mod NUM_CH, and go to ISSUE.
REQ-021 ch_ready is 0 in ISSUE, WAIT and FAULT.
REQ-022 In ISSUE: eng_start=1 for exactly that cycle, clear the timeout counter, then go to WAIT; eng_start is asserted one cycle after the transfer.
REQ-023 In WAIT: the timeout counter increments each cycle.
REQ-024 WAIT, eng_done=1: the next cycle is IDLE, anomaly_vec[eng_ch] = eng_anomaly, and ml_anomaly pulses high for one cycle if eng_anomaly=1.
REQ-025 WAIT, counter reaches TIMEOUT with no eng_done: go to FAULT.
REQ-026 WAIT, eng_done in the same cycle the counter reaches TIMEOUT: eng_done wins and no fault is raised.
REQ-027 eng_done while in IDLE or ISSUE (spurious): go to FAULT, and fault_ch = eng_ch.
REQ-028 On entry to FAULT: sensor_fault=1 and fault_ch = eng_ch; FAULT is left only by reset; eng_start and ml_anomaly remain 0.
REQ-029 anomaly_vec bits are cleared only by a normal (eng_anomaly=0) result on the same channel, or by reset.
REQ-030 eng_data and eng_ch hold their values from capture until the next transfer.
REQ-031 Round-robin fairness: with all channels continuously valid, each channel is served exactly once per NUM_CH transactions.
REQ-032 Minimum transaction spacing is 3 cycles (IDLE, ISSUE, WAIT with immediate eng_done).

Reset
REQ-033 While rst_n=0, asynchronously: state=IDLE, rr_ptr=0, counter=0, eng_start=0, eng_data=0, eng_ch=0, anomaly_vec=0, ml_anomaly=0, sensor_fault=0, fault_ch=0.
REQ-034 Reset asserted mid-transaction abandons the transaction; an eng_done arriving after reset release while in IDLE is treated as spurious under REQ-027.

Structure
REQ-035 The FSM state encodings and the default TIMEOUT belong in the shared safety parameter include, alongside the safety state encodings.
REQ-036 The round-robin grant logic is one sub-module, rr_arbiter (inputs: req vector and pointer; output: one-hot grant); everything else is flat.

Verification
REQ-037 Reset, then ch_valid=4'b0100 with data 16'h1234 -> ch_ready=4'b0100 in the same cycle; eng_start one cycle later; eng_data=16'h1234, eng_ch=2.
REQ-038 ch_valid=4'b1111 held, engine returns eng_done 2 cycles after each eng_start -> grant order 0,1,2,3,0.
REQ-039 Channel 1 result eng_anomaly=1 -> ml_anomaly high for exactly one cycle, anomaly_vec=4'b0010; a later channel-1 result with eng_anomaly=0 -> anomaly_vec=4'b0000.
REQ-040 No eng_done for 255 cycles after eng_start on channel 3 -> sensor_fault=1, fault_ch=3, ch_ready=0 thereafter, held until rst_n=0.
REQ-041 eng_done in the exact cycle the counter reaches 255 -> no fault, return to IDLE; separately, eng_done in IDLE -> sensor_fault=1.
REQ-042 rst_n pulsed low during WAIT -> all outputs take their reset values immediately; after release, a new request on channel 0 is served normally.
